// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: op codes, compare-flag selects
// and the controller state type.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SHR  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  localparam logic [1:0] FLAG_GT    = 2'b00;  // A > B
  localparam logic [1:0] FLAG_EQ    = 2'b01;  // A == B
  localparam logic [1:0] FLAG_AZERO = 2'b10;  // A == 0
  localparam logic [1:0] FLAG_AEVEN = 2'b11;  // A[0] == 0

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Multiply and divide are the only ops that go through the iterative unit.
  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative unsigned multiplier (shift-add) and restoring divider.
// One step per cycle for WIDTH cycles after 'go'. The outputs carry the value
// the current step produces, so the caller can capture the final answer on the
// same edge that completes the last step (qualified by 'valid').
module seq_muldiv_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div0
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt_r;
  logic               is_div_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   divisor_r;
  logic [2*WIDTH-1:0] prod_r;     // {partial sum, remaining multiplier bits}
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;      // dividend bits shift out, quotient bits shift in

  logic [WIDTH:0]     add_s;
  logic [2*WIDTH-1:0] prod_nxt_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [WIDTH-1:0]   quo_nxt_s;

  // One multiply step and one restoring-divide step from the current state.
  always_comb begin
    add_s      = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                 (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    prod_nxt_s = {add_s, prod_r[WIDTH-1:1]};
    shifted_s  = {rem_r, quo_r[WIDTH-1]};
    diff_s     = shifted_s - {1'b0, divisor_r};
    // A zero divisor always "fits", giving all-ones quotient and remainder = A.
    if (shifted_s >= {1'b0, divisor_r}) begin
      rem_nxt_s = diff_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt_s = shifted_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  assign valid     = busy && (cnt_r == CW'(WIDTH - 1));
  assign product   = prod_nxt_s;
  assign quotient  = quo_nxt_s;
  assign remainder = rem_nxt_s;

  // Operand capture on 'go', then one iteration per cycle until the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      cnt_r     <= '0;
      is_div_r  <= 1'b0;
      mcand_r   <= '0;
      divisor_r <= '0;
      prod_r    <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      div0      <= 1'b0;
    end else if (go && !busy) begin
      busy      <= 1'b1;
      cnt_r     <= '0;
      is_div_r  <= is_div;
      mcand_r   <= a;
      divisor_r <= b;
      prod_r    <= {{WIDTH{1'b0}}, b};
      rem_r     <= '0;
      quo_r     <= a;
      div0      <= (b == '0);
    end else if (busy) begin
      if (is_div_r) begin
        rem_r <= rem_nxt_s;
        quo_r <= quo_nxt_s;
      end else begin
        prod_r <= prod_nxt_s;
      end
      if (valid) begin
        busy  <= 1'b0;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/param_seq_alu.sv
// Registered, parametrised ALU: operand registers, single-cycle datapath,
// compare flag and start/busy/done controller around the iterative mul/div.
// rst_n is an active-high synchronous reset; the name is historical.
module param_seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               load_a,
  input  logic               load_b,
  input  logic [3:0]         op,
  input  logic [1:0]         flag_sel,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag,
  output logic               overflow
);

  state_t             state_r, state_nxt_s;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               pend_flag_r;
  logic               pend_div_r;

  logic               accept_s;
  logic               iter_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] sc_result_s;
  logic               sc_ovf_s;
  logic               flag_s;

  logic               mdu_busy, mdu_valid, mdu_div0;
  logic [2*WIDTH-1:0] mdu_product;
  logic [WIDTH-1:0]   mdu_quotient, mdu_remainder;

  assign accept_s = start && (state_r != S_RUN);
  assign iter_s   = is_iterative(op);

  seq_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst_n),
    .go        (accept_s && iter_s),
    .is_div    (op == OP_DIV),
    .a         (a_r),
    .b         (b_r),
    .busy      (mdu_busy),
    .valid     (mdu_valid),
    .product   (mdu_product),
    .quotient  (mdu_quotient),
    .remainder (mdu_remainder),
    .div0      (mdu_div0)
  );

  // Single-cycle ops; everything above bit WIDTH-1 is zero except the add carry.
  always_comb begin
    sc_result_s = '0;
    sc_ovf_s    = 1'b0;
    sum_s       = {1'b0, a_r} + {1'b0, b_r};
    case (op)
      OP_ADD: begin
        sc_result_s[WIDTH:0] = sum_s;
        sc_ovf_s             = sum_s[WIDTH];
      end
      OP_SUB: begin
        sc_result_s[WIDTH-1:0] = a_r - b_r;
        sc_ovf_s               = (a_r < b_r);
      end
      OP_SHR:  sc_result_s[WIDTH-1:0] = {1'b0, a_r[WIDTH-1:1]};
      OP_SHL: begin
        sc_result_s[WIDTH-1:0] = {a_r[WIDTH-2:0], 1'b0};
        sc_ovf_s               = a_r[WIDTH-1];
      end
      OP_AND:  sc_result_s[WIDTH-1:0] = a_r & b_r;
      OP_OR:   sc_result_s[WIDTH-1:0] = a_r | b_r;
      OP_XOR:  sc_result_s[WIDTH-1:0] = a_r ^ b_r;
      OP_PASS: sc_result_s[WIDTH-1:0] = a_r;
      default: sc_result_s = '0;  // reserved ops and mul/div (handled elsewhere)
    endcase
  end

  // Compare flag from the operand registers as they stand when start is seen.
  always_comb begin
    case (flag_sel)
      FLAG_GT:    flag_s = (a_r > b_r);
      FLAG_EQ:    flag_s = (a_r == b_r);
      FLAG_AZERO: flag_s = (a_r == '0);
      FLAG_AEVEN: flag_s = ~a_r[0];
      default:    flag_s = 1'b0;
    endcase
  end

  // Controller next state; DONE accepts a new start exactly like IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_nxt_s = iter_s ? S_RUN : S_DONE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (mdu_valid) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand registers; frozen while an iterative op is running.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_r <= '0;
      b_r <= '0;
    end else if (state_r != S_RUN) begin
      if (load_a) a_r <= din;
      if (load_b) b_r <= din;
    end
  end

  // Registered outputs: updated only when an op completes, held otherwise.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      flag        <= 1'b0;
      overflow    <= 1'b0;
      pend_flag_r <= 1'b0;
      pend_div_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nxt_s == S_RUN);
      if (accept_s && !iter_s) begin
        result   <= sc_result_s;
        overflow <= sc_ovf_s;
        flag     <= flag_s;
        done     <= 1'b1;
      end else if (accept_s) begin
        pend_flag_r <= flag_s;
        pend_div_r  <= (op == OP_DIV);
      end else if ((state_r == S_RUN) && mdu_valid) begin
        result   <= pend_div_r ? {mdu_remainder, mdu_quotient} : mdu_product;
        overflow <= pend_div_r ? mdu_div0 : (|mdu_product[2*WIDTH-1:WIDTH]);
        flag     <= pend_flag_r;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/param_seq_alu.md
# param_seq_alu

Parametrised, registered successor to the team's 8-bit combinational ALU. Operands are loaded from a shared input bus into A/B registers. A `start` pulse launches an operation. Logic, add/sub and shift ops complete in one cycle. Multiply and divide run iteratively over WIDTH cycles through a start/busy/done handshake. Result, compare flag and overflow are registered and held until the next operation completes.

## Interface
- `WIDTH`, default 8: operand width; must be ≥ 2.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-high reset; the name is kept per codebase convention despite the polarity.
- `din`  in  WIDTH  operand bus.
- `load_a`  in  1  capture `din` into A.
- `load_b`  in  1  capture `din` into B.
- `op`  in  4  operation select, sampled with `start`.
- `flag_sel`  in  2  compare-flag select, sampled with `start`.
- `start`  in  1  launch operation.
- `busy`  out  1  multi-cycle op in progress.
- `done`  out  1  one-cycle pulse: result/flag/overflow updated.
- `result`  out  2*WIDTH  registered result.
- `flag`  out  1  registered compare flag.
- `overflow`  out  1  registered overflow/exception.

## Operation
- Op encoding (unsigned throughout):
  - 0000 add: result = zero-extended A+B; overflow = carry out.
  - 0001 sub: result = A−B mod 2^WIDTH; overflow = borrow (A<B).
  - 0010 shr: A>>1; overflow 0.
  - 0011 shl: A<<1 truncated to WIDTH; overflow = A[WIDTH-1].
  - 0100 and, 0101 or, 0110 xor: overflow 0.
  - 0111 pass A: overflow 0.
  - 1000 mul: shift-add, full 2W product; overflow = (upper half ≠ 0).
  - 1001 div: restoring; result = {remainder, quotient}; overflow 0.
  - 1010–1111 reserved: result 0, overflow 0, done still pulses.
  - For all single-cycle ops, result upper W bits are 0, except the add carry at bit WIDTH.
- Divide by zero: quotient all-ones, remainder = A, overflow = 1; still takes WIDTH busy cycles.
- Flag, from A/B as sampled at start:
  - 00: A>B
  - 01: A==B
  - 10: A==0
  - 11: A[0]==0
- `load_a` and `load_b` may be asserted together; both then take `din`.
- Loads are ignored while `busy`.
- `start` is ignored while `busy`.
- `start` and a load in the same cycle: the op uses the old register values, and the load takes effect.
- FSM states:
  - IDLE: on `start` with a single-cycle op, go to DONE; with mul/div, go to RUN.
  - RUN: iteration counter 0..WIDTH-1; after the last step, go to DONE.
  - DONE: one cycle, `done`=1; return to IDLE. A `start` in DONE is accepted exactly as in IDLE.
- Reset values: A=B=0, result=0, flag=0, overflow=0, busy=0, done=0, state IDLE, counter 0.

## Timing
- `start` sampled in cycle 0:
  - Single-cycle op: result/flag/overflow valid and `done`=1 in cycle 1.
  - mul/div: `busy`=1 in cycles 1..WIDTH; result valid and `done`=1 in cycle WIDTH+1, with `busy`=0.
- Outputs are stable between `done` pulses. Intermediate iteration values never appear on `result`.
- Back-to-back: a `start` in the `done` cycle launches the next op with no gap.
- Reset asserted mid-operation: abort. All outputs take their reset values on the next edge, and no `done` pulse is issued.
- A,B load: a value written at the edge ending cycle n is usable by a `start` in cycle n+1.

## Structure
- Package `alu_pkg` holds:
  - op encoding localparams (OP_ADD … OP_DIV)
  - flag_sel encodings
  - the FSM state enum (S_IDLE, S_RUN, S_DONE)
- Sub-module `seq_muldiv_unit` (param WIDTH):
  - inputs: go, is_div, a, b
  - outputs: busy, valid, product/quotient/remainder, div0
  - owns the iteration counter and shift registers.
- Top level owns the operand registers, the single-cycle datapath, flag logic and the FSM.

## Test plan
- WIDTH=8; load A=200, B=100; op add; start → cycle 1: result=0x012C, overflow=1, done=1. Then op sub → result=0x0064, overflow=0.
- Mul 15×17 → busy for 8 cycles, done at cycle 9, result=0x00FF, overflow=0. Then 200×200 → result=0x9C40, overflow=1.
- Div 200/7 → result=0x041C (rem 4, quot 28), overflow=0. Div 200/0 → result=0xC8FF, overflow=1, still 8 busy cycles.
- During a mul: assert start (op add) and load_a=1 with din=9 → both ignored; mul completes correctly and A is unchanged.
- Reset in cycle 4 of a mul → next cycle all outputs 0, no done pulse. A following add of 3+4 gives result=7.
- Flags: A=B=5, sel 01 → flag=1; A=0, sel 10 → flag=1; A=3, sel 11 → flag=0; A=9, B=4, sel 00 → flag=1. Reserved op 1100 → result 0, done pulses.
